seg_scan_controller: RTL

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It owns an internal scan prescaler that generates the digit-rate tick. It sequences the digits with an anti-ghosting blanking gap and decodes hex nibbles to segment patterns. New display contents are accepted through a load handshake and applied only at frame boundaries, so no frame ever mixes old and new data.

---
 rtl/seg_scan_controller.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// Eight-digit multiplexed seven-segment scan controller with a blanking gap
// between digits and frame-synchronous double-buffered display updates.
module seg_scan_controller #(
  parameter int DIV_MAX   = 99999,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  en_mask_i,
  input  logic        load_i,
  output logic        busy_o,
  output logic        frame_o,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int CW = $clog2(DIV_MAX + 1);
  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DIV_MAX);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [2:0]     idx_reg, idx_next;
  logic [BW-1:0]  bcnt_reg, bcnt_next;

  logic [31:0]    sh_data_reg, act_data_reg;
  logic [7:0]     sh_dp_reg, act_dp_reg;
  logic [7:0]     sh_mask_reg, act_mask_reg;
  logic           busy_reg, frame_reg;

  logic [7:0]     an_reg, an_next;
  logic [6:0]     seg_reg, seg_next;
  logic           dp_reg, dp_next;

  logic           tick, commit;
  logic [3:0]     nib [8];

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign nib[gi] = act_data_reg[4*gi +: 4];
    end
  endgenerate

  assign tick   = (cnt_reg == CNT_MAX);
  assign commit = tick && (idx_reg == 3'd7);

  always_comb begin
    cnt_next   = tick ? '0 : cnt_reg + CW'(1);
    idx_next   = tick ? idx_reg + 3'd1 : idx_reg;
    state_next = state_reg;
    bcnt_next  = bcnt_reg;
    if (tick) begin
      state_next = ST_BLANK;
      bcnt_next  = '0;
    end else if (state_reg == ST_BLANK) begin
      if (bcnt_reg == BLANK_LAST) state_next = ST_SHOW;
      else                        bcnt_next  = bcnt_reg + BW'(1);
    end

    // Outputs are registered from next-state values. The active bank only
    // changes on a tick, when the next state is always BLANK.
    an_next  = 8'hFF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (state_next == ST_SHOW && act_mask_reg[idx_next]) begin
      an_next  = ~(8'h01 << idx_next);
      seg_next = hex_to_seg(nib[idx_next]);
      dp_next  = ~act_dp_reg[idx_next];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= ST_SHOW;
      cnt_reg   <= '0;
      idx_reg   <= 3'd7;
      bcnt_reg  <= '0;
      frame_reg <= 1'b0;
      an_reg    <= 8'hFF;
      seg_reg   <= 7'h7F;
      dp_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      bcnt_reg  <= bcnt_next;
      frame_reg <= commit;
      an_reg    <= an_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
    end
  end

  // A load coinciding with the commit tick bypasses the shadow bank.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sh_data_reg  <= '0;
      sh_dp_reg    <= '0;
      sh_mask_reg  <= '0;
      act_data_reg <= '0;
      act_dp_reg   <= '0;
      act_mask_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      if (load_i) begin
        sh_data_reg <= data_i;
        sh_dp_reg   <= dp_i;
        sh_mask_reg <= en_mask_i;
      end
      if (commit) begin
        busy_reg <= 1'b0;
        if (load_i) begin
          act_data_reg <= data_i;
          act_dp_reg   <= dp_i;
          act_mask_reg <= en_mask_i;
        end else if (busy_reg) begin
          act_data_reg <= sh_data_reg;
          act_dp_reg   <= sh_dp_reg;
          act_mask_reg <= sh_mask_reg;
        end
      end else if (load_i) begin
        busy_reg <= 1'b1;
      end
    end
  end

  assign busy_o  = busy_reg;
  assign frame_o = frame_reg;
  assign an_o    = an_reg;
  assign seg_o   = seg_reg;
  assign dp_o    = dp_reg;

endmodule
